// File: rtl/evm_pkg.sv
// Shared types and helpers for the multi-party voting machine.
package evm_pkg;

    localparam int unsigned MAX_PARTIES = 16;
    localparam int unsigned MAX_CNT_W   = 32;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOCK  = 2'd2
    } state_t;

    typedef logic [MAX_CNT_W-1:0]   tally_t;
    typedef logic [MAX_PARTIES-1:0] sel_t;
    typedef logic [IDX_W-1:0]       idx_t;

    // True when exactly one bit is set; all-zero is not one-hot.
    function automatic logic onehot(input sel_t v);
        return (v != '0) && ((v & (v - sel_t'(1))) == '0);
    endfunction

    // Lowest index holding the maximum tally (unused slots are zero).
    function automatic idx_t argmax(input tally_t t [MAX_PARTIES]);
        idx_t best;
        best = '0;
        for (int i = 1; i < MAX_PARTIES; i++) begin
            if (t[i] > t[best]) best = IDX_W'(i);
        end
        return best;
    endfunction

    // More than one party shares a nonzero maximum.
    function automatic logic has_tie(input tally_t t [MAX_PARTIES]);
        tally_t      mx;
        int unsigned n;
        mx = t[argmax(t)];
        n  = 0;
        for (int i = 0; i < MAX_PARTIES; i++) begin
            if (t[i] == mx) n++;
        end
        return (mx != '0) && (n > 1);
    endfunction

endpackage

// File: rtl/evm_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter, rising-edge press pulse.
module evm_debounce #(
    parameter int unsigned DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
    output logic db_level
);

    // Toggle on the (2^W-1)th consecutive disagreeing cycle.
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = ~DEBOUNCE_W'(1);

    logic                  sync1;
    logic                  sync2;
    logic                  valid1;
    logic                  valid2;
    logic                  seen_release;
    logic [DEBOUNCE_W-1:0] cnt;

    // seen_release blocks a press from a button already held when reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            valid1       <= 1'b0;
            valid2       <= 1'b0;
            seen_release <= 1'b0;
            cnt          <= '0;
            db_level     <= 1'b0;
            press        <= 1'b0;
        end else begin
            sync1        <= btn;
            sync2        <= sync1;
            valid1       <= 1'b1;
            valid2       <= valid1;
            seen_release <= seen_release | (valid2 & ~sync2);
            press        <= 1'b0;
            if (sync2 != db_level) begin
                if (cnt == CNT_LAST) begin
                    db_level <= sync2;
                    cnt      <= '0;
                    press    <= sync2 & seen_release;
                end else begin
                    cnt <= cnt + DEBOUNCE_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/evm_multi.sv
// Multi-party voting machine: session FSM, saturating tallies, leader/tie display.
module evm_multi
    import evm_pkg::*;
#(
    parameter int unsigned NUM_PARTIES    = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DEBOUNCE_W     = 16,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PARTIES-1:0]              vote_input,
    input  logic                                start_vote,
    input  logic                                btn,
    input  logic                                clear_req,
    output logic [NUM_PARTIES-1:0]              party_led,
    output logic                                invalid_vote,
    output logic                                vote_accepted,
    output logic                                vote_rejected,
    output logic [NUM_PARTIES*CNT_W-1:0]        party_votes,
    output logic [CNT_W+$clog2(NUM_PARTIES)-1:0] total_votes,
    output logic [$clog2(NUM_PARTIES)-1:0]      leader,
    output logic                                tie,
    output logic [1:0]                          state_o
);

    localparam int unsigned LW        = $clog2(NUM_PARTIES);
    localparam int unsigned TW        = CNT_W + LW;
    localparam int unsigned LCK_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LCK_W-1:0] LOCK_LOAD = LCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state;
    logic [CNT_W-1:0]       tally [NUM_PARTIES];
    logic [LCK_W-1:0]       lock_cnt;
    logic                   press;
    logic                   db_level;
    logic                   sel_ok;
    logic                   sel_sat;
    logic                   try_cast;
    logic [NUM_PARTIES-1:0] sat_vec;
    tally_t                 tally_ext [MAX_PARTIES];

    evm_debounce #(
        .DEBOUNCE_W(DEBOUNCE_W)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .press   (press),
        .db_level(db_level)
    );

    // Selection qualification; decisions are made in the press cycle.
    assign sel_ok        = onehot(sel_t'(vote_input));
    assign sel_sat       = |(vote_input & sat_vec);
    assign try_cast      = (state == ARMED) & start_vote & press;
    assign vote_accepted = try_cast & sel_ok & ~sel_sat;
    assign vote_rejected = try_cast & ~(sel_ok & ~sel_sat);
    assign party_led     = (rst_n & start_vote & sel_ok) ? vote_input : '0;
    assign invalid_vote  = rst_n & start_vote & ~sel_ok;
    assign state_o       = state;

    // Tally packing, saturation flags, full-width total.
    always_comb begin
        party_votes = '0;
        sat_vec     = '0;
        total_votes = '0;
        for (int i = 0; i < int'(MAX_PARTIES); i++) tally_ext[i] = '0;
        for (int i = 0; i < int'(NUM_PARTIES); i++) begin
            tally_ext[i]                 = tally_t'(tally[i]);
            party_votes[i*CNT_W +: CNT_W] = tally[i];
            sat_vec[i]                   = (tally[i] == CNT_MAX);
            total_votes                  = total_votes + TW'(tally[i]);
        end
    end

    assign leader = LW'(argmax(tally_ext));
    assign tie    = has_tie(tally_ext);

    // Session FSM with tallies and lockout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            for (int i = 0; i < int'(NUM_PARTIES); i++) tally[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        for (int i = 0; i < int'(NUM_PARTIES); i++) tally[i] <= '0;
                    end
                    if (start_vote) state <= ARMED;
                end
                ARMED: begin
                    if (vote_accepted) begin
                        for (int i = 0; i < int'(NUM_PARTIES); i++) begin
                            if (vote_input[i]) tally[i] <= tally[i] + CNT_W'(1);
                        end
                        lock_cnt <= LOCK_LOAD;
                        state    <= LOCK;
                    end else if (!start_vote) begin
                        state <= IDLE;
                    end
                end
                LOCK: begin
                    if (lock_cnt != '0) begin
                        lock_cnt <= lock_cnt - LCK_W'(1);
                    end else if (!db_level) begin
                        state <= start_vote ? ARMED : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_evm_multi.sv
// Self-checking bench for evm_multi with a tally-level reference model.
module tb_evm_multi;

    localparam int NP = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] vote_input;
    logic          start_vote;
    logic          btn;
    logic          clear_req;
    logic [NP-1:0] party_led;
    logic          invalid_vote;
    logic          vote_accepted;
    logic          vote_rejected;
    logic [NP*CW-1:0] party_votes;
    logic [CW+1:0] total_votes;
    logic [1:0]    leader;
    logic          tie;
    logic [1:0]    state_o;

    int vectors = 0;
    int miscompares = 0;
    int acc_cnt = 0;
    int rej_cnt = 0;
    int m_tally [NP];

    evm_multi #(
        .NUM_PARTIES(NP), .CNT_W(CW), .DEBOUNCE_W(3), .LOCKOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vote_input(vote_input), .start_vote(start_vote),
        .btn(btn), .clear_req(clear_req), .party_led(party_led),
        .invalid_vote(invalid_vote), .vote_accepted(vote_accepted),
        .vote_rejected(vote_rejected), .party_votes(party_votes),
        .total_votes(total_votes), .leader(leader), .tie(tie), .state_o(state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        acc_cnt += int'(vote_accepted);
        rej_cnt += int'(vote_rejected);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [NP*CW-1:0] exp_votes();
        logic [NP*CW-1:0] v;
        for (int i = 0; i < NP; i++) v[i*CW +: CW] = CW'(m_tally[i]);
        return v;
    endfunction

    function automatic int exp_total();
        int s = 0;
        for (int i = 0; i < NP; i++) s += m_tally[i];
        return s;
    endfunction

    function automatic int exp_leader();
        int best = 0;
        for (int i = 1; i < NP; i++) if (m_tally[i] > m_tally[best]) best = i;
        return best;
    endfunction

    function automatic logic exp_tie();
        int mx = m_tally[exp_leader()];
        int n = 0;
        for (int i = 0; i < NP; i++) if (m_tally[i] == mx) n++;
        return (mx > 0) && (n > 1);
    endfunction

    // One full press/release; the model decides what the machine should have done.
    task automatic do_press(input logic [NP-1:0] sel, output int got_a, output int got_r,
                            output int exp_a, output int exp_r);
        int a0, r0, idx;
        vote_input = sel;
        cyc(2);
        a0 = acc_cnt;
        r0 = rej_cnt;
        btn = 1'b1;
        cyc(20);
        btn = 1'b0;
        cyc(20);
        got_a = acc_cnt - a0;
        got_r = rej_cnt - r0;
        exp_a = 0;
        exp_r = 0;
        if ($countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < NP; i++) if (sel[i]) idx = i;
            if (m_tally[idx] < (1 << CW) - 1) begin
                m_tally[idx]++;
                exp_a = 1;
            end else begin
                exp_r = 1;
            end
        end else begin
            exp_r = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vote_input = '0; start_vote = 1'b0; btn = 1'b0; clear_req = 1'b0;
        for (int i = 0; i < NP; i++) m_tally[i] = 0;
        cyc(3);
        @(negedge clk);
        vectors++;
        if (party_votes !== '0 || total_votes !== '0 || leader !== '0 || tie !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tallies: votes=%h total=%0d leader=%0d tie=%b, want all 0",
                     party_votes, total_votes, leader, tie);
        end
        vectors++;
        if (state_o !== 2'd0 || vote_accepted !== 1'b0 || vote_rejected !== 1'b0 ||
            party_led !== '0 || invalid_vote !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: state=%0d acc=%b rej=%b led=%b inv=%b, want all 0",
                     state_o, vote_accepted, vote_rejected, party_led, invalid_vote);
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(5);
    endtask

    task automatic test_first_vote();
        logic found;
        int a0;
        start_vote = 1'b1;
        vote_input = 4'b0010;
        cyc(2);
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd1 || party_led !== 4'b0010 || invalid_vote !== 1'b0) begin
            miscompares++;
            $display("FAIL first_armed: state=%0d led=%b inv=%b, want 1 0010 0",
                     state_o, party_led, invalid_vote);
        end
        cyc(1);
        a0 = acc_cnt;
        btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (vote_accepted) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL first_accept_timeout: no vote_accepted within 40 cycles");
        end
        vectors++;
        if (party_votes !== exp_votes()) begin
            miscompares++;
            $display("FAIL first_pre_increment: votes=%h want %h", party_votes, exp_votes());
        end
        if (found) m_tally[1]++;
        @(negedge clk);
        vectors++;
        if (party_votes !== exp_votes() || total_votes !== 6'(exp_total()) ||
            leader !== 2'(exp_leader()) || tie !== exp_tie()) begin
            miscompares++;
            $display("FAIL first_tally: votes=%h total=%0d leader=%0d tie=%b want %h %0d %0d %b",
                     party_votes, total_votes, leader, tie, exp_votes(), exp_total(),
                     exp_leader(), exp_tie());
        end
        cyc(10);
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd2) begin
            miscompares++;
            $display("FAIL first_lock: state=%0d want 2", state_o);
        end
        cyc(1);
        btn = 1'b0;
        cyc(20);
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd1 || acc_cnt - a0 != 1) begin
            miscompares++;
            $display("FAIL first_release: state=%0d accepts=%0d want 1 1", state_o, acc_cnt - a0);
        end
        cyc(1);
    endtask

    task automatic test_glitch();
        int a0, r0;
        vote_input = 4'b0010;
        cyc(2);
        a0 = acc_cnt;
        r0 = rej_cnt;
        repeat (8) begin
            btn = 1'b1;
            cyc($urandom_range(1, 6));
            btn = 1'b0;
            cyc(12);
        end
        vectors++;
        if (acc_cnt != a0 || rej_cnt != r0 || party_votes !== exp_votes()) begin
            miscompares++;
            $display("FAIL glitch: accepts=%0d rejects=%0d votes=%h want 0 0 %h",
                     acc_cnt - a0, rej_cnt - r0, party_votes, exp_votes());
        end
    endtask

    task automatic test_invalid();
        logic [NP-1:0] sels [2];
        int ga, gr, ea, er;
        sels[0] = 4'b0110;
        sels[1] = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            vote_input = sels[s];
            cyc(1);
            @(negedge clk);
            vectors++;
            if (invalid_vote !== 1'b1 || party_led !== '0) begin
                miscompares++;
                $display("FAIL invalid_flag: sel=%b inv=%b led=%b want 1 0000",
                         sels[s], invalid_vote, party_led);
            end
            do_press(sels[s], ga, gr, ea, er);
            @(negedge clk);
            vectors++;
            if (ga != ea || gr != er || state_o !== 2'd1 || party_votes !== exp_votes()) begin
                miscompares++;
                $display("FAIL invalid_press: sel=%b acc=%0d rej=%0d state=%0d votes=%h want %0d %0d 1 %h",
                         sels[s], ga, gr, state_o, party_votes, ea, er, exp_votes());
            end
        end
    endtask

    task automatic test_saturate();
        int ga, gr, ea, er;
        start_vote = 1'b0;
        cyc(2);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        for (int i = 0; i < NP; i++) m_tally[i] = 0;
        start_vote = 1'b1;
        cyc(2);
        for (int p = 0; p < 16; p++) begin
            do_press(4'b1000, ga, gr, ea, er);
            vectors++;
            if (ga != ea || gr != er) begin
                miscompares++;
                $display("FAIL sat_press%0d: acc=%0d rej=%0d want %0d %0d", p, ga, gr, ea, er);
            end
        end
        @(negedge clk);
        vectors++;
        if (party_votes !== exp_votes() || total_votes !== 6'(exp_total()) || leader !== 2'd3) begin
            miscompares++;
            $display("FAIL sat_final: votes=%h total=%0d leader=%0d want %h %0d 3",
                     party_votes, total_votes, leader, exp_votes(), exp_total());
        end
        cyc(1);
    endtask

    task automatic test_tie_clear();
        int ga, gr, ea, er;
        start_vote = 1'b0;
        cyc(2);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        for (int i = 0; i < NP; i++) m_tally[i] = 0;
        start_vote = 1'b1;
        cyc(2);
        do_press(4'b0001, ga, gr, ea, er);
        do_press(4'b0100, ga, gr, ea, er);
        @(negedge clk);
        vectors++;
        if (leader !== 2'(exp_leader()) || tie !== exp_tie() || party_votes !== exp_votes()) begin
            miscompares++;
            $display("FAIL tie: leader=%0d tie=%b votes=%h want %0d %b %h",
                     leader, tie, party_votes, exp_leader(), exp_tie(), exp_votes());
        end
        cyc(1);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        cyc(1);
        @(negedge clk);
        vectors++;
        if (party_votes !== exp_votes()) begin
            miscompares++;
            $display("FAIL clear_in_armed: votes=%h want %h", party_votes, exp_votes());
        end
        cyc(1);
        start_vote = 1'b0;
        cyc(2);
        clear_req = 1'b1;
        start_vote = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        for (int i = 0; i < NP; i++) m_tally[i] = 0;
        cyc(1);
        @(negedge clk);
        vectors++;
        if (party_votes !== '0 || total_votes !== '0 || tie !== 1'b0 || state_o !== 2'd1) begin
            miscompares++;
            $display("FAIL clear_start: votes=%h total=%0d tie=%b state=%0d want 0 0 0 1",
                     party_votes, total_votes, tie, state_o);
        end
        cyc(1);
    endtask

    task automatic test_random();
        logic [NP-1:0] sel;
        int ga, gr, ea, er;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 4) == 0) sel = NP'($urandom_range(0, 15));
            else sel = NP'(1 << $urandom_range(0, NP - 1));
            do_press(sel, ga, gr, ea, er);
            @(negedge clk);
            vectors++;
            if (ga != ea || gr != er || party_votes !== exp_votes() ||
                total_votes !== 6'(exp_total()) || leader !== 2'(exp_leader()) ||
                tie !== exp_tie()) begin
                miscompares++;
                $display("FAIL random%0d sel=%b: acc=%0d rej=%0d votes=%h total=%0d ldr=%0d tie=%b want %0d %0d %h %0d %0d %b",
                         n, sel, ga, gr, party_votes, total_votes, leader, tie,
                         ea, er, exp_votes(), exp_total(), exp_leader(), exp_tie());
            end
        end
        cyc(1);
    endtask

    task automatic test_reset_in_lock();
        logic found;
        int a0, ga, gr, ea, er;
        vote_input = 4'b0001;
        cyc(2);
        btn = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (vote_accepted) found = 1'b1;
        end
        cyc(2);
        @(negedge clk);
        vectors++;
        if (!found || state_o !== 2'd2) begin
            miscompares++;
            $display("FAIL lock_before_reset: found=%b state=%0d want 1 2", found, state_o);
        end
        cyc(1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NP; i++) m_tally[i] = 0;
        vectors++;
        if (party_votes !== '0 || total_votes !== '0 || state_o !== 2'd0 || leader !== '0 ||
            tie !== 1'b0 || party_led !== '0 || invalid_vote !== 1'b0 ||
            vote_accepted !== 1'b0 || vote_rejected !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_lock: votes=%h total=%0d state=%0d led=%b inv=%b want all 0",
                     party_votes, total_votes, state_o, party_led, invalid_vote);
        end
        cyc(3);
        rst_n = 1'b1;
        a0 = acc_cnt;
        cyc(30);
        vectors++;
        if (acc_cnt != a0 || party_votes !== '0) begin
            miscompares++;
            $display("FAIL held_after_reset: accepts=%0d votes=%h want 0 0", acc_cnt - a0, party_votes);
        end
        btn = 1'b0;
        cyc(20);
        do_press(4'b0001, ga, gr, ea, er);
        @(negedge clk);
        vectors++;
        if (ga != ea || gr != er || party_votes !== exp_votes()) begin
            miscompares++;
            $display("FAIL repress_after_reset: acc=%0d rej=%0d votes=%h want %0d %0d %h",
                     ga, gr, party_votes, ea, er, exp_votes());
        end
    endtask

    initial begin
        test_reset();
        test_first_vote();
        test_glitch();
        test_invalid();
        test_saturate();
        test_tie_clear();
        test_random();
        test_reset_in_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
